// File: rtl/mac_pkg.sv
// Shared definitions for the lane-parallel MAC: default geometry, width and
// latency helpers, saturation mode constants and the sideband bundle that
// travels with each beat through the pipeline.
package mac_pkg;

  localparam int unsigned BwDefault    = 8;
  localparam int unsigned PrDefault    = 16;
  localparam int unsigned BwAccDefault = 32;

  localparam bit SatWrap  = 1'b0;
  localparam bit SatClamp = 1'b1;

  // Group framing carried next to the data. Signedness is consumed at the
  // product stage, so it does not need to ride further down the pipe.
  typedef struct packed {
    logic first;
    logic last;
  } mac_sb_t;

  // Lossless tree-sum width for pr lanes of bw x bw products, signed or unsigned.
  function automatic int unsigned psum_w(int unsigned bw, int unsigned pr);
    return 2 * bw + $clog2(pr) + 1;
  endfunction

  // Edges from the sampling edge of a closing beat to out_valid.
  function automatic int unsigned mac_latency(int unsigned pr);
    return $clog2(pr) + 2;
  endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// Fully registered binary adder tree.
//   clk, rst : clock, async active-high reset
//   valid_i  : beat qualifier entering the tree, sb_i its sideband
//   data_i   : Pr signed lanes of InW bits, lane i at data_i[i*InW +: InW]
//   valid_o, sb_o, sum_o : $clog2(Pr) cycles later, sum_o is OutW bits signed
// Nodes are stored heap-style: node k has children 2k+1 and 2k+2; indices
// Pr-1 .. 2Pr-2 are the (unregistered) leaves, so every internal node is one
// register and the perfect tree gives exactly $clog2(Pr) stages.
module mac_adder_tree #(
  parameter int unsigned Pr   = 16,
  parameter int unsigned InW  = 17,
  parameter int unsigned OutW = 21,
  parameter int unsigned SbW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  input  logic [SbW-1:0]         sb_i,
  input  logic [Pr*InW-1:0]      data_i,
  output logic                   valid_o,
  output logic [SbW-1:0]         sb_o,
  output logic signed [OutW-1:0] sum_o
);

  localparam int unsigned Levels = $clog2(Pr);

  logic signed [OutW-1:0] leaf   [Pr];
  logic signed [OutW-1:0] node_d [Pr-1];
  logic signed [OutW-1:0] node_q [Pr-1];

  logic [Levels-1:0]          vld_d, vld_q;
  logic [Levels-1:0][SbW-1:0] sb_d, sb_q;

  for (genvar i = 0; i < Pr; i++) begin : g_leaf
    assign leaf[i] = {{(OutW-InW){data_i[i*InW+InW-1]}}, data_i[i*InW +: InW]};
  end

  for (genvar k = 0; k < Pr - 1; k++) begin : g_node
    if (2 * k + 1 >= Pr - 1) begin : g_from_leaves
      assign node_d[k] = leaf[2*k+1-(Pr-1)] + leaf[2*k+2-(Pr-1)];
    end else begin : g_from_nodes
      assign node_d[k] = node_q[2*k+1] + node_q[2*k+2];
    end
  end

  always_comb begin
    vld_d    = vld_q;
    sb_d     = sb_q;
    vld_d[0] = valid_i;
    sb_d[0]  = sb_i;
    for (int i = 1; i < Levels; i++) begin
      vld_d[i] = vld_q[i-1];
      sb_d[i]  = sb_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < Pr - 1; k++) node_q[k] <= '0;
      vld_q <= '0;
      sb_q  <= '0;
    end else begin
      for (int k = 0; k < Pr - 1; k++) node_q[k] <= node_d[k];
      vld_q <= vld_d;
      sb_q  <= sb_d;
    end
  end

  assign valid_o = vld_q[Levels-1];
  assign sb_o    = sb_q[Levels-1];
  assign sum_o   = node_q[0];

endmodule

// File: rtl/mac_lanes_acc_pipelined.sv
// Pipelined pr-lane dot product with a multi-beat group accumulator.
//   clk, rst            : clock, async active-high reset
//   in_valid            : beat qualifier; in_first/in_last frame a group,
//                         in_signed selects two's complement lanes per beat
//   a, b                : pr lanes of bw bits, lane i at [bw*i +: bw]
//   out, out_valid, ovf : group result (signed, bw_acc bits), one-cycle
//                         valid pulse, sticky overflow of that group
// Stages: product regs, $clog2(pr) tree levels, accumulator, output register.
module mac_lanes_acc_pipelined
  import mac_pkg::*;
#(
  parameter int unsigned bw      = BwDefault,
  parameter int unsigned pr      = PrDefault,
  parameter int unsigned bw_psum = psum_w(bw, pr),
  parameter int unsigned bw_acc  = BwAccDefault,
  parameter bit          SAT     = SatWrap
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_first,
  input  logic                in_last,
  input  logic                in_signed,
  input  logic [pr*bw-1:0]    a,
  input  logic [pr*bw-1:0]    b,
  output logic [bw_acc-1:0]   out,
  output logic                out_valid,
  output logic                ovf
);

  localparam int unsigned Pw = 2 * bw + 1;

  // Product stage
  logic [pr*Pw-1:0] prod_d, prod_q;
  logic             s0_vld_q;
  mac_sb_t          s0_sb_q;

  // Operands are widened by one bit (sign or zero) so a single signed
  // multiply covers both modes; the low Pw bits hold the exact product.
  for (genvar i = 0; i < pr; i++) begin : g_lane
    logic signed [bw:0]   a_ext, b_ext;
    logic signed [Pw-1:0] p;
    assign a_ext = {in_signed & a[bw*(i+1)-1], a[bw*i +: bw]};
    assign b_ext = {in_signed & b[bw*(i+1)-1], b[bw*i +: bw]};
    assign p     = Pw'(a_ext) * Pw'(b_ext);
    assign prod_d[i*Pw +: Pw] = p;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q   <= '0;
      s0_vld_q <= 1'b0;
      s0_sb_q  <= '0;
    end else begin
      s0_vld_q <= in_valid;
      if (in_valid) begin
        prod_q  <= prod_d;
        s0_sb_q <= '{first: in_first, last: in_last};
      end
    end
  end

  // Adder tree
  logic                      tree_vld;
  mac_sb_t                   tree_sb;
  logic signed [bw_psum-1:0] tree_sum;

  mac_adder_tree #(
    .Pr   (pr),
    .InW  (Pw),
    .OutW (bw_psum),
    .SbW  ($bits(mac_sb_t))
  ) u_tree (
    .clk     (clk),
    .rst     (rst),
    .valid_i (s0_vld_q),
    .sb_i    (s0_sb_q),
    .data_i  (prod_q),
    .valid_o (tree_vld),
    .sb_o    (tree_sb),
    .sum_o   (tree_sum)
  );

  // Accumulator stage
  logic signed [bw_acc-1:0] acc_d, acc_q, sum_ext, base, raw;
  logic                     acc_ovf_d, acc_ovf_q;
  logic                     open_d, open_q;
  logic                     emit_d, emit_q;
  logic                     ovf_now;

  always_comb begin
    sum_ext   = bw_acc'(tree_sum);
    base      = tree_sb.first ? '0 : acc_q;
    raw       = base + sum_ext;
    ovf_now   = (base[bw_acc-1] == sum_ext[bw_acc-1]) && (raw[bw_acc-1] != base[bw_acc-1]);
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    open_d    = open_q;
    emit_d    = 1'b0;
    if (tree_vld) begin
      acc_d = raw;
      if (SAT && ovf_now) begin
        acc_d = sum_ext[bw_acc-1] ? {1'b1, {(bw_acc-1){1'b0}}} : {1'b0, {(bw_acc-1){1'b1}}};
      end
      acc_ovf_d = (tree_sb.first ? 1'b0 : acc_ovf_q) | ovf_now;
      open_d    = open_q | tree_sb.first;
      // A closing beat only reports if a group was ever opened since reset.
      emit_d    = tree_sb.last & (tree_sb.first | open_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      open_q    <= 1'b0;
      emit_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      open_q    <= open_d;
      emit_q    <= emit_d;
    end
  end

  // Output stage
  logic [bw_acc-1:0] out_d, out_q;
  logic              out_valid_d, out_valid_q;
  logic              ovf_d, ovf_q;

  always_comb begin
    out_d       = emit_q ? acc_q : out_q;
    out_valid_d = emit_q;
    ovf_d       = acc_ovf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule
